// File: rtl/irq_pending_latch_pkg.sv
// Shared definitions for the interrupt pending latch: line count, index width
// and the handshake FSM state encoding.
package irq_pending_latch_pkg;

    localparam int NUM_LINES = 4;
    localparam int IDX_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic logic [NUM_LINES-1:0] onehot(input logic [IDX_W-1:0] idx);
        return NUM_LINES'(1) << idx;
    endfunction

endpackage

// File: rtl/priority_encoder_4to2.sv
// Combinational 4-to-2 priority encoder: Y is the index of the highest set D,
// V flags that any input is set.
module priority_encoder_4to2 (
    input  logic       D3,
    input  logic       D2,
    input  logic       D1,
    input  logic       D0,
    output logic [1:0] Y,
    output logic       V
);

    always_comb begin
        Y = 2'd0;
        if (D3)      Y = 2'd3;
        else if (D2) Y = 2'd2;
        else if (D1) Y = 2'd1;
        V = D3 | D2 | D1 | D0;
    end

endmodule

// File: rtl/req_sync_edge.sv
// Per-line request synchroniser with an edge (or level) detector on the
// synchronised value.
module req_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic hit
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], raw};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign hit = EDGE_MODE ? (chain[SYNC_STAGES-1] & ~prev) : chain[SYNC_STAGES-1];

endmodule

// File: rtl/irq_pending_latch.sv
// Request stage ahead of the priority encoder: sticky pending/overflow bits
// per line and a valid/ready offer of the encoder's winning index.
module irq_pending_latch
    import irq_pending_latch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_LINES-1:0] req_raw,
    input  logic [NUM_LINES-1:0] mask,
    output logic                 D3,
    output logic                 D2,
    output logic                 D1,
    output logic                 D0,
    input  logic [IDX_W-1:0]     enc_y,
    input  logic                 enc_v,
    output logic                 irq_valid,
    output logic [IDX_W-1:0]     irq_idx,
    input  logic                 irq_ready,
    output logic [NUM_LINES-1:0] ovf,
    input  logic [NUM_LINES-1:0] ovf_clr
);

    logic [NUM_LINES-1:0] hit;
    logic [NUM_LINES-1:0] pend;
    logic [NUM_LINES-1:0] clear;
    logic                 accept;
    state_t               state;
    state_t               state_nxt;
    logic                 valid_nxt;
    logic [IDX_W-1:0]     idx_nxt;

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        req_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_MODE   (EDGE_MODE)
        ) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (req_raw[i]),
            .hit   (hit[i])
        );
    end

    assign accept = irq_valid & irq_ready;
    assign clear  = accept ? onehot(irq_idx) : '0;

    // A fresh edge beats the accept-clear, and then counts as a new request rather than an overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            ovf  <= '0;
        end else begin
            pend <= hit | (pend & ~clear);
            ovf  <= (hit & pend & ~clear) | (ovf & ~ovf_clr);
        end
    end

    assign {D3, D2, D1, D0} = pend & mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            irq_valid <= 1'b0;
            irq_idx   <= '0;
        end else begin
            state     <= state_nxt;
            irq_valid <= valid_nxt;
            irq_idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (enc_v)  state_nxt = ST_OFFER;
            ST_OFFER: if (accept) state_nxt = ST_GAP;
            ST_GAP:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // The index is frozen once captured, so later pending or mask changes cannot preempt an offer.
    always_comb begin
        valid_nxt = (state == ST_OFFER) && !accept;
        idx_nxt   = irq_idx;
        if (state == ST_IDLE && enc_v) idx_nxt = enc_y;
    end

endmodule
